// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control decoder: opcodes, control-bundle bit positions,
// interrupt FSM encodings and the combinational instruction decoder.
package ctrl_pkg;

  localparam int CTRL_W = 16;

  localparam logic [4:0] OP_R     = 5'h0C;
  localparam logic [4:0] OP_I     = 5'h04;
  localparam logic [4:0] OP_LOAD  = 5'h00;
  localparam logic [4:0] OP_STORE = 5'h08;
  localparam logic [4:0] OP_BR    = 5'h18;
  localparam logic [4:0] OP_JAL   = 5'h1B;
  localparam logic [4:0] OP_JALR  = 5'h19;
  localparam logic [4:0] OP_SYS   = 5'h1C;

  localparam int CB_MEM_TO_REG = 15;
  localparam int CB_MEM_WRITE  = 14;
  localparam int CB_ALU_SRC    = 13;
  localparam int CB_REG_WRITE  = 12;
  localparam int CB_ECALL      = 11;
  localparam int CB_S_TYPE     = 10;
  localparam int CB_BEQ        = 9;
  localparam int CB_BNE        = 8;
  localparam int CB_JAL        = 7;
  localparam int CB_JALR       = 6;
  localparam int CB_HALF       = 5;
  localparam int CB_BGE        = 4;
  localparam int CB_CSR        = 3;
  localparam int CB_BLT        = 2;
  localparam int CB_BLTU       = 1;
  localparam int CB_BYTE       = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAKE  = 2'd1,
    ST_SERVE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic              is_uret;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic en_ext);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    f3 = instr[14:12];
    f7 = instr[31:25];
    imm = instr[31:20];
    d.ctrl = '0;
    d.illegal = 1'b0;
    d.is_uret = 1'b0;
    if (instr[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (instr[6:2])
        OP_R: begin
          d.ctrl[CB_REG_WRITE] = 1'b1;
          d.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end
        OP_I: begin
          d.ctrl[CB_ALU_SRC] = 1'b1;
          d.ctrl[CB_REG_WRITE] = 1'b1;
          d.illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        end
        OP_LOAD: begin
          d.ctrl[CB_MEM_TO_REG] = 1'b1;
          d.ctrl[CB_ALU_SRC] = 1'b1;
          d.ctrl[CB_REG_WRITE] = 1'b1;
          case (f3)
            3'd2:       d.illegal = 1'b0;
            3'd5:       d.ctrl[CB_HALF] = 1'b1;
            3'd0, 3'd4: begin
              d.ctrl[CB_BYTE] = 1'b1;
              d.illegal = !en_ext;
            end
            default:    d.illegal = 1'b1;
          endcase
        end
        OP_STORE: begin
          d.ctrl[CB_MEM_WRITE] = 1'b1;
          d.ctrl[CB_ALU_SRC] = 1'b1;
          d.ctrl[CB_S_TYPE] = 1'b1;
          case (f3)
            3'd2: d.illegal = 1'b0;
            3'd0: begin
              d.ctrl[CB_BYTE] = 1'b1;
              d.illegal = !en_ext;
            end
            default: d.illegal = 1'b1;
          endcase
        end
        OP_BR: begin
          case (f3)
            3'd0: d.ctrl[CB_BEQ] = 1'b1;
            3'd1: d.ctrl[CB_BNE] = 1'b1;
            3'd5: d.ctrl[CB_BGE] = 1'b1;
            3'd4: begin
              d.ctrl[CB_BLT] = 1'b1;
              d.illegal = !en_ext;
            end
            3'd6: begin
              d.ctrl[CB_BLTU] = 1'b1;
              d.illegal = !en_ext;
            end
            default: d.illegal = 1'b1;
          endcase
        end
        OP_JAL: begin
          d.ctrl[CB_JAL] = 1'b1;
          d.ctrl[CB_REG_WRITE] = 1'b1;
        end
        OP_JALR: begin
          d.ctrl[CB_JALR] = 1'b1;
          d.ctrl[CB_REG_WRITE] = 1'b1;
          d.ctrl[CB_ALU_SRC] = 1'b1;
          d.illegal = (f3 != 3'd0);
        end
        OP_SYS: begin
          case (f3)
            3'd0: begin
              if (instr[19:7] != 13'd0) d.illegal = 1'b1;
              else if (imm == 12'h000) d.ctrl[CB_ECALL] = 1'b1;
              else if (imm == 12'h002) d.is_uret = 1'b1;
              else d.illegal = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7: begin
              d.ctrl[CB_CSR] = 1'b1;
              d.ctrl[CB_REG_WRITE] = 1'b1;
            end
            default: d.illegal = 1'b1;
          endcase
        end
        default: d.illegal = 1'b1;
      endcase
    end
    if (d.illegal) d.ctrl = '0;
    else d.ctrl = d.ctrl;
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode_pipe_irq_stack.sv
// LIFO of interrupt indices currently in service; pop wins over push when both are requested.
module irq_nest_stack
  #(parameter int DEPTH = 2,
    parameter int W = 2,
    localparam int DW = $clog2(DEPTH + 1))
  (input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  top_o,
   output logic [DW-1:0] depth_o,
   output logic          empty_o,
   output logic          full_o);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DW'(DEPTH));
  assign depth_o = depth_q;

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_o = (depth_q == DW'(i + 1)) ? mem_q[i] : top_o;
    end
  end

  always_comb begin
    mem_d = mem_q;
    depth_d = depth_q;
    if (pop_i && !empty_o) begin
      depth_d = depth_q - ONE;
    end else if (push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = (depth_q == DW'(i)) ? data_i : mem_q[i];
      end
      depth_d = depth_q + ONE;
    end else begin
      depth_d = depth_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX control register with stall/flush and a nestable, prioritised interrupt sequencer
// that bubbles the pipe and pulses irq_take for each interrupt entry.
module ctrl_decode_pipe
  import ctrl_pkg::*;
  #(parameter int NUM_IRQ = 3,
    parameter int NEST_DEPTH = 2,
    parameter int EN_EXT = 1,
    localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int DW = $clog2(NEST_DEPTH + 1))
  (input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [31:0]        id_instr,
   input  logic               ex_stall,
   input  logic               ex_flush,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               irq_en,
   output logic               id_ready,
   output logic               ex_valid,
   output logic [CTRL_W-1:0]  ex_ctrl,
   output logic               ex_illegal,
   output logic               irq_take,
   output logic [IRQ_W-1:0]   irq_id,
   output logic               irq_busy,
   output logic               uret_ack);

  irq_state_e        state_q, state_d;
  dec_t              dec_s;
  logic              ex_valid_q, ex_valid_d, ex_illegal_q, ex_illegal_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic              uret_ack_q, uret_ack_d;
  logic              irq_take_s, id_ready_s, uret_pop_s, qualify_s, push_s, any_req_s;
  logic [IRQ_W-1:0]  win_s, top_s;
  logic [DW-1:0]     depth_s;
  logic              empty_s, full_s;

  irq_nest_stack #(.DEPTH(NEST_DEPTH), .W(IRQ_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .push_i(push_s), .pop_i(uret_pop_s), .data_i(win_s),
    .top_o(top_s), .depth_o(depth_s), .empty_o(empty_s), .full_o(full_s));

  // Lowest set request index wins.
  always_comb begin
    win_s = '0;
    any_req_s = |irq_req;
    for (int i = NUM_IRQ - 1; i >= 0; i--) win_s = irq_req[i] ? IRQ_W'(i) : win_s;
  end

  always_comb begin
    dec_s = decode(id_instr, EN_EXT != 0);
    id_ready_s = !ex_flush && !ex_stall && !irq_take_s;
    uret_pop_s = id_ready_s && id_valid && dec_s.is_uret && !empty_s;
    // A uret pop blocks a take this cycle; the request is re-judged against the new top.
    qualify_s = irq_en && any_req_s && (empty_s || (win_s < top_s)) && !full_s &&
                !ex_flush && !ex_stall && !uret_pop_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    case (state_q)
      ST_IDLE:  state_d = qualify_s ? ST_TAKE : ST_IDLE;
      ST_TAKE:  state_d = ST_SERVE;
      ST_SERVE: begin
        if (qualify_s) state_d = ST_TAKE;
        else if (uret_pop_s && depth_s == DW'(1)) state_d = ST_IDLE;
        else state_d = ST_SERVE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_take_s = (state_q == ST_TAKE);
    push_s = qualify_s && (state_q != ST_TAKE);
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d = ex_ctrl_q;
    ex_illegal_d = ex_illegal_q;
    uret_ack_d = uret_pop_s;
    if (ex_flush || (!ex_stall && irq_take_s)) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d = '0;
      ex_illegal_d = 1'b0;
    end else if (ex_stall) begin
      ex_valid_d = ex_valid_q;
    end else begin
      ex_valid_d = id_valid;
      ex_ctrl_d = id_valid ? dec_s.ctrl : '0;
      ex_illegal_d = id_valid && (dec_s.illegal || (dec_s.is_uret && empty_s));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q <= '0;
      ex_illegal_q <= 1'b0;
      uret_ack_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q <= ex_ctrl_d;
      ex_illegal_q <= ex_illegal_d;
      uret_ack_q <= uret_ack_d;
    end
  end

  assign id_ready   = id_ready_s;
  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_illegal = ex_illegal_q;
  assign irq_take   = irq_take_s;
  assign irq_id     = top_s;
  assign irq_busy   = !empty_s;
  assign uret_ack   = uret_ack_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench: decode bundles, stall/flush, interrupt take/nesting/uret and async reset.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, ex_stall, ex_flush, irq_en;
  logic [31:0] id_instr;
  logic [2:0]  irq_req;
  logic        id_ready, ex_valid, ex_illegal, irq_take, irq_busy, uret_ack;
  logic [15:0] ex_ctrl;
  logic [1:0]  irq_id;
  logic        n1_id_ready, n1_ex_valid, n1_ex_illegal, n1_irq_take, n1_irq_busy, n1_uret_ack;
  logic [15:0] n1_ex_ctrl;
  logic [1:0]  n1_irq_id;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] ADDI = 32'h00500093, ADD = 32'h002081B3, SUB = 32'h402081B3;
  localparam logic [31:0] LW = 32'h0000A283, URET = 32'h00200073;

  logic [31:0] dec_instr [8] = '{32'h0000D283, 32'h00008283, 32'h00508023, 32'h0020C063,
                                 32'h000000EF, 32'h30046073, 32'h00000073, 32'h0000A283};
  logic [15:0] dec_ctrl  [8] = '{16'hB020, 16'hB001, 16'h6401, 16'h0004,
                                 16'h1080, 16'h1008, 16'h0800, 16'hB000};

  ctrl_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .irq_req(irq_req), .irq_en(irq_en), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal), .irq_take(irq_take),
    .irq_id(irq_id), .irq_busy(irq_busy), .uret_ack(uret_ack));

  ctrl_decode_pipe #(.NEST_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .ex_stall(ex_stall),
    .ex_flush(ex_flush), .irq_req(irq_req), .irq_en(irq_en), .id_ready(n1_id_ready),
    .ex_valid(n1_ex_valid), .ex_ctrl(n1_ex_ctrl), .ex_illegal(n1_ex_illegal),
    .irq_take(n1_irq_take), .irq_id(n1_irq_id), .irq_busy(n1_irq_busy), .uret_ack(n1_uret_ack));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; ex_stall = 1'b0; ex_flush = 1'b0;
    irq_req = 3'b000; irq_en = 1'b0;
    #12;
    checks++; if ({ex_valid, ex_ctrl, ex_illegal, irq_take, irq_id, irq_busy, uret_ack} !== 22'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", {ex_valid, ex_ctrl, ex_illegal, irq_take, irq_id, irq_busy, uret_ack}); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", id_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_addi();
    id_valid = 1'b1; id_instr = ADDI;
    tick();
    checks++; if (ex_ctrl !== 16'h3000) begin errors++; $display("FAIL addi_ctrl: got %h want 3000", ex_ctrl); end
    checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b0) begin errors++; $display("FAIL addi_valid: got v=%b i=%b want v=1 i=0", ex_valid, ex_illegal); end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 8; i++) begin
      id_instr = dec_instr[i];
      tick();
      checks++; if (ex_ctrl !== dec_ctrl[i] || ex_illegal !== 1'b0) begin errors++; $display("FAIL decode_%0d: instr %h got %h ill=%b want %h ill=0", i, dec_instr[i], ex_ctrl, ex_illegal, dec_ctrl[i]); end
    end
  endtask

  task automatic test_stall_flush();
    id_instr = ADD;
    tick();
    checks++; if (ex_ctrl !== 16'h1000) begin errors++; $display("FAIL add_ctrl: got %h want 1000", ex_ctrl); end
    ex_stall = 1'b1; id_instr = SUB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b want 0", i, id_ready); end
      tick();
      checks++; if (ex_ctrl !== 16'h1000 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: got %h v=%b want 1000 v=1", i, ex_ctrl, ex_valid); end
    end
    id_instr = LW;
    tick();
    checks++; if (ex_ctrl !== 16'h1000) begin errors++; $display("FAIL stall_hold_lw: got %h want 1000", ex_ctrl); end
    ex_flush = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0000) begin errors++; $display("FAIL flush_bubble: got v=%b %h want v=0 0000", ex_valid, ex_ctrl); end
    ex_flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
    tick();
  endtask

  task automatic test_irq_take();
    irq_en = 1'b1; irq_req = 3'b110;
    tick();
    checks++; if (irq_take !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL take1: got take=%b id=%0d want take=1 id=1", irq_take, irq_id); end
    checks++; if (ex_valid !== 1'b0 || irq_busy !== 1'b1 || id_ready !== 1'b0) begin errors++; $display("FAIL take1_state: got v=%b busy=%b rdy=%b want 0 1 0", ex_valid, irq_busy, id_ready); end
    id_valid = 1'b1; id_instr = ADDI;
    tick();
    checks++; if (irq_take !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL take1_after: got take=%b v=%b want 0 0", irq_take, ex_valid); end
    checks++; if (irq_busy !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL serve1: got busy=%b id=%0d want 1 1", irq_busy, irq_id); end
  endtask

  task automatic test_nest_uret();
    id_valid = 1'b0; irq_req = 3'b111;
    tick();
    checks++; if (irq_take !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL nest_take: got take=%b id=%0d want 1 0", irq_take, irq_id); end
    checks++; if (n1_irq_take !== 1'b0) begin errors++; $display("FAIL depth1_no_take: got %b want 0", n1_irq_take); end
    tick();
    checks++; if (irq_take !== 1'b0 || n1_irq_take !== 1'b0 || n1_irq_id !== 2'd1) begin errors++; $display("FAIL nest_after: got take=%b n1take=%b n1id=%0d want 0 0 1", irq_take, n1_irq_take, n1_irq_id); end
    irq_req = 3'b000; id_valid = 1'b1; id_instr = URET;
    tick();
    checks++; if (uret_ack !== 1'b1 || irq_id !== 2'd1 || irq_busy !== 1'b1) begin errors++; $display("FAIL uret1: got ack=%b id=%0d busy=%b want 1 1 1", uret_ack, irq_id, irq_busy); end
    checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b0 || n1_irq_busy !== 1'b0) begin errors++; $display("FAIL uret1_ex: got v=%b ill=%b n1busy=%b want 1 0 0", ex_valid, ex_illegal, n1_irq_busy); end
    tick();
    checks++; if (uret_ack !== 1'b1 || irq_busy !== 1'b0 || irq_id !== 2'd0) begin errors++; $display("FAIL uret2: got ack=%b busy=%b id=%0d want 1 0 0", uret_ack, irq_busy, irq_id); end
    checks++; if (n1_ex_illegal !== 1'b1 || n1_uret_ack !== 1'b0) begin errors++; $display("FAIL n1_uret_empty: got ill=%b ack=%b want 1 0", n1_ex_illegal, n1_uret_ack); end
  endtask

  task automatic test_illegal();
    id_instr = URET;
    tick();
    checks++; if (ex_illegal !== 1'b1 || uret_ack !== 1'b0 || ex_ctrl !== 16'h0000) begin errors++; $display("FAIL uret_empty: got ill=%b ack=%b ctrl=%h want 1 0 0000", ex_illegal, uret_ack, ex_ctrl); end
    id_instr = 32'hFFFFFFFF;
    tick();
    checks++; if (ex_illegal !== 1'b1 || ex_ctrl !== 16'h0000 || ex_valid !== 1'b1) begin errors++; $display("FAIL all_ones: got ill=%b ctrl=%h v=%b want 1 0000 1", ex_illegal, ex_ctrl, ex_valid); end
  endtask

  task automatic test_reset_mid_serve();
    id_instr = ADDI; irq_req = 3'b100;
    tick();
    checks++; if (irq_take !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL take2: got take=%b id=%0d want 1 2", irq_take, irq_id); end
    tick();
    tick();
    checks++; if (irq_busy !== 1'b1 || ex_valid !== 1'b1 || ex_ctrl !== 16'h3000) begin errors++; $display("FAIL serve2_pre: got busy=%b v=%b ctrl=%h want 1 1 3000", irq_busy, ex_valid, ex_ctrl); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ex_valid, ex_ctrl, ex_illegal, irq_take, irq_id, irq_busy, uret_ack} !== 22'd0) begin errors++; $display("FAIL reset_mid: got %h want 0", {ex_valid, ex_ctrl, ex_illegal, irq_take, irq_id, irq_busy, uret_ack}); end
    checks++; if (irq_busy !== 1'b0 || n1_irq_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b n1=%b want 0 0", irq_busy, n1_irq_busy); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_stall_flush();
    test_irq_take();
    test_nest_uret();
    test_illegal();
    test_reset_mid_serve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
